// File: rtl/ysyx_23060171_arb_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter.
package ysyx_23060171_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    IFU = 1'b0,
    LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/ysyx_23060171_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU and LSU,
// with a response watchdog that returns an error instead of hanging.
module ysyx_23060171_mem_arbiter
  import ysyx_23060171_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic        ifu_rsp_err,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic        lsu_rsp_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t       r_state;
  arb_owner_t       r_owner;
  arb_owner_t       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic             r_wen;
  logic [31:0]      r_wdata;
  logic [7:0]       r_wmask;

  logic w_idle, w_grant_ifu, w_grant_lsu;
  logic w_rsp_ok, w_timeout, w_rsp_fire;

  // On conflict the master that did not win last time is granted.
  assign w_idle      = (r_state == IDLE);
  assign w_grant_lsu = w_idle && lsu_req_valid && (!ifu_req_valid || r_last == IFU);
  assign w_grant_ifu = w_idle && ifu_req_valid && !w_grant_lsu;

  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  assign w_rsp_ok   = (r_state == WAIT) && mem_rsp_valid;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == WAIT) && !mem_rsp_valid
                      && (r_cnt == CNT_LAST);
  assign w_rsp_fire = w_rsp_ok || w_timeout;

  assign ifu_rsp_valid = w_rsp_fire && (r_owner == IFU);
  assign ifu_rsp_err   = w_timeout && (r_owner == IFU);
  assign ifu_rdata     = (w_rsp_ok && r_owner == IFU) ? mem_rdata : '0;
  assign lsu_rsp_valid = w_rsp_fire && (r_owner == LSU);
  assign lsu_rsp_err   = w_timeout && (r_owner == LSU);
  assign lsu_rdata     = (w_rsp_ok && r_owner == LSU) ? mem_rdata : '0;

  assign mem_req_valid = (r_state == REQ);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= IFU;
      r_last  <= IFU;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_lsu) begin
            r_owner <= LSU;
            r_last  <= LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_wmask <= lsu_wmask;
            r_state <= REQ;
          end else if (w_grant_ifu) begin
            r_owner <= IFU;
            r_last  <= IFU;
            r_addr  <= ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_state <= WAIT;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_state <= DRAIN;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // The late response belonging to the timed-out request is swallowed.
          if (mem_rsp_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
